// File: rtl/corefifo_wr_ptr_gray_enc_if.sv
// Write-side pointer bus of the async COREFIFO: write request and incoming read
// pointer in, RAM address, write pointers and status out.
interface corefifo_wr_ptr_gray_enc_if #(
  parameter int ADDRWIDTH = 3
);
  logic                 wr_en;
  logic [ADDRWIDTH:0]   rd_gray_in;
  logic [ADDRWIDTH-1:0] wr_addr;
  logic [ADDRWIDTH:0]   wr_bin;
  logic [ADDRWIDTH:0]   wr_gray_out;
  logic                 full;
  logic                 wr_ack;
  logic                 overflow;
  logic [ADDRWIDTH:0]   wr_count;

  modport master (
    output wr_en, rd_gray_in,
    input  wr_addr, wr_bin, wr_gray_out, full, wr_ack, overflow, wr_count
  );

  modport slave (
    input  wr_en, rd_gray_in,
    output wr_addr, wr_bin, wr_gray_out, full, wr_ack, overflow, wr_count
  );
endinterface

// File: rtl/corefifo_wr_ptr_gray_enc.sv
// Write-domain pointer logic for the async COREFIFO: binary/Gray write pointer,
// read-pointer synchroniser, and full / overflow / fill count derived from it.
module corefifo_wr_ptr_gray_enc #(
  parameter int ADDRWIDTH   = 3,
  parameter int SYNC_STAGES = 2
) (
  input logic                      clk,
  input logic                      reset,
  corefifo_wr_ptr_gray_enc_if.slave bus
);
  localparam int PW = ADDRWIDTH + 1;

  logic [PW-1:0] r_wr_bin;
  logic [PW-1:0] r_wr_gray;
  logic [PW-1:0] r_wr_count;
  logic          r_full;
  logic          r_wr_ack;
  logic          r_overflow;
  logic [PW-1:0] r_sync [SYNC_STAGES];

  logic          w_accept;
  logic [PW-1:0] w_bin_nxt;
  logic [PW-1:0] w_gray_nxt;
  logic [PW-1:0] w_rq;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_full_gray;

  assign w_accept   = bus.wr_en && !r_full;
  assign w_bin_nxt  = r_wr_bin + PW'(w_accept);
  assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);
  assign w_rq       = r_sync[SYNC_STAGES-1];
  // Write pointer one full lap ahead of the read pointer: top two Gray bits inverted.
  assign w_full_gray = {~w_rq[PW-1:PW-2], w_rq[PW-3:0]};

  always_comb begin
    // NOTE: default first so every bit is assigned on every pass; no latch inferred.
    w_rbin = '0;
    for (int i = 0; i < PW; i++) begin
      w_rbin[i] = ^(w_rq >> i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_bin   <= '0;
      r_wr_gray  <= '0;
      r_wr_count <= '0;
      r_full     <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_overflow <= 1'b0;
      // NOTE: the sync chain is cleared too, so a stale read pointer cannot leak into the count after reset.
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_sync[0] <= bus.rd_gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_wr_bin   <= w_bin_nxt;
      r_wr_gray  <= w_gray_nxt;
      r_full     <= (w_gray_nxt == w_full_gray);
      r_wr_count <= w_bin_nxt - w_rbin;
      r_wr_ack   <= w_accept;
      r_overflow <= bus.wr_en && r_full;
    end
  end

  assign bus.wr_addr     = r_wr_bin[ADDRWIDTH-1:0];
  assign bus.wr_bin      = r_wr_bin;
  assign bus.wr_gray_out = r_wr_gray;
  assign bus.full        = r_full;
  assign bus.wr_ack      = r_wr_ack;
  assign bus.overflow    = r_overflow;
  assign bus.wr_count    = r_wr_count;
endmodule
